// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_if
// Brief    : Digit load handshake and display pin bundle for seg_scan_driver.
// Revision : 1.0  initial release
// ============================================================================
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dots_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic                    update_i;
    logic                    update_ack_o;
    logic                    frame_o;
    logic [7:0]              segments_cathode_o;
    logic [NUM_DIGITS-1:0]   segments_anode_o;

    // Producer of digit values (the calculator core)
    modport master (
        output digits_i,
        output dots_i,
        output blank_i,
        output update_i,
        input  update_ack_o,
        input  frame_o,
        input  segments_cathode_o,
        input  segments_anode_o
    );

    // The scan driver itself
    modport slave (
        input  digits_i,
        input  dots_i,
        input  blank_i,
        input  update_i,
        output update_ack_o,
        output frame_o,
        output segments_cathode_o,
        output segments_anode_o
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Multiplexed common-anode 7-segment scanner with frame-aligned
//            shadow load and inter-digit dead time (active-low pins).
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 4,
    parameter int DEAD_CYCLES  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    seg_scan_driver_if.slave     bus
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [0:0]       c_ST_DARK    = 1'b0;
    localparam logic [0:0]       c_ST_ON      = 1'b1;
    localparam logic [CNT_W-1:0] c_DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam bit               c_NO_DEAD    = (DEAD_CYCLES == 0);

    logic [0:0]              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dots;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [7:0]              r_cathode;
    logic                    r_ack;
    logic                    r_frame;

    logic                    w_last_on;
    logic                    w_boundary;
    logic                    w_load;
    logic                    w_dark_done;
    logic                    w_lit;
    logic [3:0]              w_nibble;
    logic [7:0]              w_glyph;
    logic [7:0]              w_cathode;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_last_on   = (r_state == c_ST_ON) && (r_cnt == c_DIGIT_LAST);
    assign w_boundary  = w_last_on && (r_idx == c_IDX_LAST);
    // A request raised in the boundary cycle itself still makes this frame's load
    assign w_load      = w_boundary && (r_pending || bus.update_i);
    assign w_dark_done = c_NO_DEAD || (r_cnt == c_DEAD_LAST);

    assign w_lit    = (r_state == c_ST_ON) && !r_sh_blank[r_idx];
    assign w_nibble = r_sh_digits[{r_idx, 2'b00} +: 4];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    always_comb begin
        w_glyph = 8'hFF;
        case (w_nibble)
            4'h0: w_glyph = 8'hC0;
            4'h1: w_glyph = 8'hF9;
            4'h2: w_glyph = 8'hA4;
            4'h3: w_glyph = 8'hB0;
            4'h4: w_glyph = 8'h99;
            4'h5: w_glyph = 8'h92;
            4'h6: w_glyph = 8'h82;
            4'h7: w_glyph = 8'hF8;
            4'h8: w_glyph = 8'h80;
            4'h9: w_glyph = 8'h90;
            4'hA: w_glyph = 8'h88;
            4'hB: w_glyph = 8'h83;
            4'hC: w_glyph = 8'hC6;
            4'hD: w_glyph = 8'hA1;
            4'hE: w_glyph = 8'h86;
            4'hF: w_glyph = 8'h8E;
            default: w_glyph = 8'hFF;
        endcase
    end

    assign w_cathode = {w_glyph[7] & ~r_sh_dots[r_idx], w_glyph[6:0]};

    // Scan sequencer: DARK for DEAD_CYCLES, then ON for DIGIT_CYCLES, per digit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_DARK;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_DARK: begin
                    if (w_dark_done) begin
                        r_state <= c_ST_ON;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                c_ST_ON: begin
                    if (w_last_on) begin
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                        r_state <= c_NO_DEAD ? c_ST_ON : c_ST_DARK;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_DARK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Load request bookkeeping and frame-aligned shadow capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending   <= 1'b0;
            r_sh_digits <= '0;
            r_sh_dots   <= '0;
            r_sh_blank  <= '1;
            r_ack       <= 1'b0;
            r_frame     <= 1'b0;
        end else begin
            r_ack   <= w_load;
            r_frame <= w_boundary;
            if (w_load) begin
                r_pending   <= 1'b0;
                r_sh_digits <= bus.digits_i;
                r_sh_dots   <= bus.dots_i;
                r_sh_blank  <= bus.blank_i;
            end else if (bus.update_i) begin
                r_pending   <= 1'b1;
            end
        end
    end

    // Pins follow the scan state one cycle late; all-off unless a lit digit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_anode   <= '1;
            r_cathode <= 8'hFF;
        end else if (w_lit) begin
            r_anode   <= ~w_onehot;
            r_cathode <= w_cathode;
        end else begin
            r_anode   <= '1;
            r_cathode <= 8'hFF;
        end
    end

    assign bus.segments_anode_o   = r_anode;
    assign bus.segments_cathode_o = r_cathode;
    assign bus.update_ack_o       = r_ack;
    assign bus.frame_o            = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Randomised self-checking bench for seg_scan_driver against a
//            time-indexed reference model of the scan sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_NUM    = 8;
    localparam int c_DIGIT  = 4;
    localparam int c_DEAD   = 2;
    localparam int c_PERIOD = c_DIGIT + c_DEAD;
    localparam int c_FRAME  = c_PERIOD * c_NUM;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seg_scan_driver_if #(.NUM_DIGITS(c_NUM)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (c_NUM),
        .DIGIT_CYCLES (c_DIGIT),
        .DEAD_CYCLES  (c_DEAD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position in the frame comes straight from the cycle count
    logic [7:0]  seg_tab [16];
    int          k;
    logic [31:0] m_dig;
    logic [7:0]  m_dot;
    logic [7:0]  m_blank;
    logic        m_pend;
    logic [7:0]  e_an;
    logic [7:0]  e_cat;
    logic        e_ack;
    logic        e_frame;

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; m_pend = 1'b0; m_dig = '0; m_dot = '0; m_blank = '1;
            e_an = 8'hFF; e_cat = 8'hFF; e_ack = 1'b0; e_frame = 1'b0;
        end else begin
            int  p, d;
            bool_lit_calc: begin
                p = k % c_FRAME;
                d = p / c_PERIOD;
                if ((p % c_PERIOD) >= c_DEAD && !m_blank[d]) begin
                    e_an  = ~(8'd1 << d);
                    e_cat = seg_tab[m_dig[d*4 +: 4]];
                    if (m_dot[d]) e_cat[7] = 1'b0;
                end else begin
                    e_an  = 8'hFF;
                    e_cat = 8'hFF;
                end
            end
            e_frame = (p == c_FRAME - 1);
            e_ack   = e_frame && (m_pend || bus.update_i);
            if (e_ack) begin
                m_dig = bus.digits_i; m_dot = bus.dots_i; m_blank = bus.blank_i;
                m_pend = 1'b0;
            end else if (bus.update_i) begin
                m_pend = 1'b1;
            end
            k++;
        end
    end

    always @(negedge clk) begin
        check("anode",   {24'h0, bus.segments_anode_o},   {24'h0, e_an});
        check("cathode", {24'h0, bus.segments_cathode_o}, {24'h0, e_cat});
        check("ack",     {31'h0, bus.update_ack_o},       {31'h0, e_ack});
        check("frame",   {31'h0, bus.frame_o},            {31'h0, e_frame});
    end

    task automatic do_update(input logic [31:0] dg, input logic [7:0] dt,
                             input logic [7:0] bl, input int len);
        int  acks;
        bool_seen: begin
            acks = 0;
            bus.digits_i = dg; bus.dots_i = dt; bus.blank_i = bl;
            bus.update_i = 1'b1;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                if (bus.update_ack_o) acks++;
            end
            bus.update_i = 1'b0;
            for (int i = 0; i < 2 * c_FRAME + 8 && acks == 0; i++) begin
                @(negedge clk);
                if (bus.update_ack_o) acks++;
            end
            if (acks == 0) check("ack_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_frame();
        bit got;
        got = 1'b0;
        for (int i = 0; i < c_FRAME + 8 && !got; i++) begin
            @(negedge clk);
            got = bus.frame_o;
        end
        if (!got) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pos(input int pos);
        bit got;
        got = 1'b0;
        for (int i = 0; i < c_FRAME + 8 && !got; i++) begin
            @(negedge clk);
            got = ((k % c_FRAME) == pos);
        end
        if (!got) check("pos_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int gap, acks;
        bit seen8, seen1, seen_b3, seen_dp;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.digits_i = '0; bus.dots_i = '0; bus.blank_i = '0; bus.update_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_anode", {24'h0, bus.segments_anode_o}, 32'hFF);
        check("rst_cathode", {24'h0, bus.segments_cathode_o}, 32'hFF);
        rst_n = 1'b1;

        // Load a value, then reset in the middle of a lit digit
        do_update(32'h12345678, 8'h00, 8'h00, 1);
        wait_pos(20);
        #1 rst_n = 1'b0;
        #1;
        check("async_anode", {24'h0, bus.segments_anode_o}, 32'hFF);
        check("async_cathode", {24'h0, bus.segments_cathode_o}, 32'hFF);
        check("async_ack", {31'h0, bus.update_ack_o}, 32'h0);
        check("async_frame", {31'h0, bus.frame_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic load, inspected over the frame after the ack
        do_update(32'h12345678, 8'h00, 8'h00, 1);
        wait_frame();
        seen8 = 1'b0; seen1 = 1'b0;
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            if (bus.segments_anode_o == 8'hFE && bus.segments_cathode_o == 8'h80) seen8 = 1'b1;
            if (bus.segments_anode_o == 8'h7F && bus.segments_cathode_o == 8'hF9) seen1 = 1'b1;
        end
        check("digit0_is_8", {31'h0, seen8}, 32'h1);
        check("digit7_is_1", {31'h0, seen1}, 32'h1);

        // Frame period
        wait_frame();
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.frame_o && gap < 2 * c_FRAME);
        check("frame_period", gap, c_FRAME);

        // Blank and dot handling
        do_update(32'hABCDEF00, 8'h01, 8'h08, 2);
        wait_frame();
        seen_b3 = 1'b0; seen_dp = 1'b0;
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            if (!bus.segments_anode_o[3]) seen_b3 = 1'b1;
            if (bus.segments_anode_o == 8'hFE && bus.segments_cathode_o == 8'h40) seen_dp = 1'b1;
        end
        check("blank_digit3", {31'h0, seen_b3}, 32'h0);
        check("digit0_dp", {31'h0, seen_dp}, 32'h1);

        // Mid-frame update, then one raised only in the boundary cycle
        wait_pos(17);
        do_update(32'h0F1E2D3C, 8'hA5, 8'h00, 3);
        wait_pos(c_FRAME - 1);
        bus.digits_i = 32'h9876FEDC; bus.dots_i = 8'h80; bus.blank_i = 8'h00;
        bus.update_i = 1'b1;
        @(negedge clk);
        bus.update_i = 1'b0;
        check("boundary_ack", {31'h0, bus.update_ack_o}, 32'h1);
        check("boundary_frame", {31'h0, bus.frame_o}, 32'h1);
        repeat (c_FRAME + 4) @(negedge clk);

        // Pending request discarded by reset; display returns to dark
        wait_pos(10);
        bus.digits_i = 32'h55555555; bus.update_i = 1'b1;
        @(negedge clk);
        bus.update_i = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 2 * c_FRAME + 4; i++) begin
            @(negedge clk);
            if (bus.update_ack_o) acks++;
        end
        check("no_ack_after_reset", acks, 0);

        // Random loads with random spacing and request lengths
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            do_update($urandom, 8'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
        end
        repeat (c_FRAME + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
